// File: rtl/hash_out_serializer.sv
// hash_out_serializer
// Transmit side of the 8-bit host interface. Captures the final BLAKE2b state
// in one cycle and streams the first nn digest bytes, byte 0 first, advancing
// one byte per cycle in which the registered enable is high.
module hash_out_serializer #(
    parameter  int BYTES = 64,
    localparam int CNT_W = $clog2(BYTES)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 en_i,
    input  logic [CNT_W-1:0]     nn_i,
    input  logic                 h_v_i,
    input  logic [8*BYTES-1:0]   h_i,
    output logic                 ready_o,
    output logic                 hash_v_o,
    output logic [7:0]           hash_o,
    output logic                 hash_last_o,
    output logic                 done_o,
    output logic                 overrun_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W:0]       cnt_q, cnt_d;
    logic [CNT_W:0]       len_q, len_d;
    logic [8*BYTES-1:0]   shreg_q, shreg_d;
    logic                 en_q;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;

    logic [CNT_W:0]       len_new;
    logic                 last_byte;
    logic                 sending;

    // A zero digest length stands for the full state width; the count is one
    // bit wider than nn_i so that the full length compares without wrapping.
    assign len_new   = (nn_i == '0) ? (CNT_W+1)'(BYTES) : {1'b0, nn_i};
    assign last_byte = (cnt_q == (len_q - 1'b1));
    assign sending   = (state_q == SEND);

    // Registered enable: gates the advance of the stream but never the capture.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_i;
        end
    end

    // State, counter, length, shift register and the two event pulses.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            shreg_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            shreg_q   <= shreg_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic: capture when idle, shift out one byte per enabled cycle
    // while sending, and flag any new state that arrives while still busy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        shreg_d   = shreg_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (h_v_i) begin
                    shreg_d = h_i;
                    len_d   = len_new;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (h_v_i) begin
                    overrun_d = 1'b1;
                end
                if (en_q) begin
                    shreg_d = shreg_q >> 8;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_byte) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced to zero whenever no valid byte is on the bus.
    always_comb begin
        ready_o     = ~sending;
        hash_v_o    = sending & en_q;
        hash_o      = hash_v_o ? shreg_q[7:0] : 8'h00;
        hash_last_o = hash_v_o & last_byte;
        done_o      = done_q;
        overrun_o   = overrun_q;
    end

endmodule
